// File: rtl/crc_pkg.sv
// Shared definitions for the CRC8/CRC15 APB wrapper and its stream feeder.
package crc_pkg;

    localparam int CRC8_W  = 8;
    localparam int CRC15_W = 15;

    // Wrapper register map (byte addresses)
    localparam logic [31:0] write_crc8  = 32'h0000_0000;
    localparam logic [31:0] read_crc8   = 32'h0000_0004;
    localparam logic [31:0] write_crc15 = 32'h0000_0008;
    localparam logic [31:0] read_crc15  = 32'h0000_000C;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_ACCESS,
        RD_SETUP,
        RD_ACCESS,
        RESULT
    } crc_mst_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on the slave; flags the last allowed one.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic p_clk_i,
    input  logic p_rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Wait-cycle counter: clear wins over count
    always_ff @(posedge p_clk_i) begin
        if (p_rst_i || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expired only on the TIMEOUT-th waiting cycle, so a ready in that cycle still wins
    assign expired = en && (cnt == CNT_LAST);

endmodule

// File: rtl/crc_apb_master.sv
// Byte-stream to APB master feeding the CRC8/CRC15 wrapper.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for next byte; drops bytes while discarding a frame
// WR_SETUP  | APB write setup phase, byte to write_crc8/15
// WR_ACCESS | APB write access phase, waiting on m_ready_i
// RD_SETUP  | APB read setup phase of read_crc8/15
// RD_ACCESS | APB read access phase, captures CRC on m_ready_i
// RESULT    | result presented, waiting on res_ready_i
module crc_apb_master
    import crc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              p_clk_i,
    input  logic              p_rst_i,
    input  logic [7:0]        s_dat_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    input  logic              s_sel15_i,
    output logic              s_ready_o,
    output logic [ADDR_W-1:0] m_adr_o,
    output logic [DATA_W-1:0] m_dat_o,
    input  logic [DATA_W-1:0] m_dat_i,
    output logic              m_sel_o,
    output logic              m_enable_o,
    output logic              m_we_o,
    input  logic              m_ready_i,
    output logic [15:0]       res_crc_o,
    output logic              res_err_o,
    output logic              res_valid_o,
    input  logic              res_ready_i
);

    crc_mst_state_t state_q, state_d;

    logic [7:0]  byte_q;
    logic        last_q;
    logic        sel15_q;
    logic        frame_active;
    logic        discard;
    logic [15:0] res_crc_q;
    logic        res_err_q;
    logic        rst_q;

    logic        accept;
    logic        in_access;
    logic        tmr_en;
    logic        tmr_clr;
    logic        tmr_expired;
    logic [15:0] rd_crc;
    logic        unused_dat_hi;

    assign accept    = s_valid_i && s_ready_o;
    assign in_access = (state_q == WR_ACCESS) || (state_q == RD_ACCESS);
    assign tmr_en    = in_access && !m_ready_i;
    assign tmr_clr   = in_access && (m_ready_i || tmr_expired);

    assign rd_crc = sel15_q ? {1'b0, m_dat_i[CRC15_W-1:0]}
                            : {8'b0, m_dat_i[CRC8_W-1:0]};
    assign unused_dat_hi = ^m_dat_i[DATA_W-1:CRC15_W];

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .p_clk_i (p_clk_i),
        .p_rst_i (p_rst_i),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register
    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!discard) begin
                        state_d = WR_SETUP;
                    end else if (s_last_i) begin
                        state_d = RESULT;
                    end
                end
            end
            WR_SETUP: state_d = WR_ACCESS;
            WR_ACCESS: begin
                if (m_ready_i) begin
                    state_d = last_q ? RD_SETUP : IDLE;
                end else if (tmr_expired) begin
                    state_d = last_q ? RESULT : IDLE;
                end
            end
            RD_SETUP: state_d = RD_ACCESS;
            RD_ACCESS: begin
                if (m_ready_i || tmr_expired) begin
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // APB and handshake outputs decoded from the current state
    always_comb begin
        s_ready_o   = 1'b0;
        m_sel_o     = 1'b0;
        m_enable_o  = 1'b0;
        m_we_o      = 1'b0;
        m_adr_o     = '0;
        m_dat_o     = '0;
        res_valid_o = 1'b0;
        case (state_q)
            IDLE: s_ready_o = !rst_q;
            WR_SETUP, WR_ACCESS: begin
                m_sel_o    = 1'b1;
                m_enable_o = (state_q == WR_ACCESS);
                m_we_o     = 1'b1;
                m_adr_o    = ADDR_W'(sel15_q ? write_crc15 : write_crc8);
                m_dat_o    = DATA_W'(byte_q);
            end
            RD_SETUP, RD_ACCESS: begin
                m_sel_o    = 1'b1;
                m_enable_o = (state_q == RD_ACCESS);
                m_adr_o    = ADDR_W'(sel15_q ? read_crc15 : read_crc8);
            end
            RESULT: res_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign res_crc_o = res_crc_q;
    assign res_err_o = res_err_q;

    // Holds s_ready_o low for the cycle after any reset so every output reads 0 then
    always_ff @(posedge p_clk_i) begin
        rst_q <= p_rst_i;
    end

    // Frame context, discard flag and result capture
    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            byte_q       <= '0;
            last_q       <= 1'b0;
            sel15_q      <= 1'b0;
            frame_active <= 1'b0;
            discard      <= 1'b0;
            res_crc_q    <= '0;
            res_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        byte_q <= s_dat_i;
                        last_q <= s_last_i;
                        if (!frame_active) begin
                            sel15_q      <= s_sel15_i;
                            frame_active <= 1'b1;
                        end
                        if (discard && s_last_i) begin
                            discard      <= 1'b0;
                            frame_active <= 1'b0;
                            res_crc_q    <= '0;
                            res_err_q    <= 1'b1;
                        end
                    end
                end
                WR_ACCESS: begin
                    if (!m_ready_i && tmr_expired) begin
                        if (last_q) begin
                            frame_active <= 1'b0;
                            res_crc_q    <= '0;
                            res_err_q    <= 1'b1;
                        end else begin
                            discard <= 1'b1;
                        end
                    end
                end
                RD_ACCESS: begin
                    if (m_ready_i) begin
                        frame_active <= 1'b0;
                        res_crc_q    <= rd_crc;
                        res_err_q    <= 1'b0;
                    end else if (tmr_expired) begin
                        frame_active <= 1'b0;
                        res_crc_q    <= '0;
                        res_err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_apb_master.sv
// Scoreboard bench for crc_apb_master with a configurable APB slave model.
module tb_crc_apb_master;
    import crc_pkg::*;

    localparam int TIMEOUT = 16;

    logic        p_clk_i = 1'b0;
    logic        p_rst_i = 1'b1;
    logic [7:0]  s_dat_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_last_i = 1'b0;
    logic        s_sel15_i = 1'b0;
    logic        s_ready_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i = '0;
    logic        m_sel_o;
    logic        m_enable_o;
    logic        m_we_o;
    logic        m_ready_i = 1'b0;
    logic [15:0] res_crc_o;
    logic        res_err_o;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;

    crc_apb_master #(
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .p_clk_i     (p_clk_i),
        .p_rst_i     (p_rst_i),
        .s_dat_i     (s_dat_i),
        .s_valid_i   (s_valid_i),
        .s_last_i    (s_last_i),
        .s_sel15_i   (s_sel15_i),
        .s_ready_o   (s_ready_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_dat_i     (m_dat_i),
        .m_sel_o     (m_sel_o),
        .m_enable_o  (m_enable_o),
        .m_we_o      (m_we_o),
        .m_ready_i   (m_ready_i),
        .res_crc_o   (res_crc_o),
        .res_err_o   (res_err_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i)
    );

    always #5 p_clk_i = ~p_clk_i;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } apb_t;

    apb_t        exp_apb[$];
    apb_t        obs_apb[$];
    logic [16:0] exp_res[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int wait_cycles = 0;
    bit never_ready = 1'b0;
    int acc_cnt = 0;
    int sel_cycles = 0;
    int en_cycles = 0;
    int res_cycles = 0;

    function automatic apb_t mk(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        apb_t t;
        t.adr = adr;
        t.we  = we;
        t.dat = dat;
        return t;
    endfunction

    always @(posedge p_clk_i) cyc <= cyc + 1;

    // Slave model and bus monitor, evaluated mid-cycle
    always @(negedge p_clk_i) begin
        if (m_sel_o) sel_cycles++;
        if (res_valid_o) res_cycles++;
        if (m_sel_o && m_enable_o) begin
            en_cycles++;
            m_ready_i = !never_ready && (acc_cnt >= wait_cycles);
            acc_cnt++;
            if (m_ready_i) obs_apb.push_back(mk(m_adr_o, m_we_o, m_dat_o));
        end else begin
            m_ready_i = 1'b0;
            acc_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic last, input logic sel15);
        int n;
        n = 0;
        @(negedge p_clk_i);
        s_dat_i = d;
        s_last_i = last;
        s_sel15_i = sel15;
        s_valid_i = 1'b1;
        while (!s_ready_o && n < 100) begin
            @(negedge p_clk_i);
            n++;
        end
        if (!s_ready_o) begin
            checks++;
            failures++;
            $display("FAIL accept_bound: s_ready_o=%0b after %0d cycles, required 1", s_ready_o, n);
        end
        @(posedge p_clk_i);
        #1;
        acc_cyc = cyc;
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        @(negedge p_clk_i);
        while (!res_valid_o && n < 100) begin
            @(negedge p_clk_i);
            n++;
        end
        ok = res_valid_o;
    endtask

    task automatic release_result();
        @(negedge p_clk_i);
        res_ready_i = 1'b1;
        @(posedge p_clk_i);
        #1;
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [85:0] outs;
        p_rst_i = 1'b1;
        repeat (2) @(posedge p_clk_i);
        @(negedge p_clk_i);
        outs = {s_ready_o, m_adr_o, m_dat_o, m_sel_o, m_enable_o, m_we_o,
                res_crc_o, res_err_o, res_valid_o};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        p_rst_i = 1'b0;
        repeat (2) @(negedge p_clk_i);
        checks++;
        if ({s_ready_o, m_sel_o, res_valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL reset_idle: ready/sel/valid=%b required 100", {s_ready_o, m_sel_o, res_valid_o});
        end
    endtask

    task automatic test_crc8_frame();
        bit ok;
        apb_t e, o;
        logic [16:0] r;
        wait_cycles = 1;
        never_ready = 1'b0;
        m_dat_i = 32'h0000_00C5;
        exp_apb.push_back(mk(write_crc8, 1'b1, 32'h0000_00AA));
        exp_apb.push_back(mk(write_crc8, 1'b1, 32'h0000_0033));
        exp_apb.push_back(mk(read_crc8, 1'b0, 32'h0));
        exp_res.push_back({1'b0, 16'h00C5});
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL crc8_valid: res_valid_o=%0b required 1", res_valid_o);
        end
        r = exp_res.pop_front();
        checks++;
        if ({res_err_o, res_crc_o} !== r) begin
            failures++;
            $display("FAIL crc8_result: err/crc=%h required %h", {res_err_o, res_crc_o}, r);
        end
        release_result();
        checks++;
        if (obs_apb.size() != exp_apb.size()) begin
            failures++;
            $display("FAIL crc8_apb_count: got %0d required %0d", obs_apb.size(), exp_apb.size());
        end
        while (exp_apb.size() > 0 && obs_apb.size() > 0) begin
            e = exp_apb.pop_front();
            o = obs_apb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL crc8_apb_xfer: got %h required %h", o, e);
            end
        end
        exp_apb.delete();
        obs_apb.delete();
    endtask

    task automatic test_crc15_frame();
        bit ok;
        apb_t e, o;
        logic [16:0] r;
        wait_cycles = 1;
        never_ready = 1'b0;
        m_dat_i = 32'h0000_D7A3;
        exp_apb.push_back(mk(write_crc15, 1'b1, 32'h0000_00AA));
        exp_apb.push_back(mk(write_crc15, 1'b1, 32'h0000_0033));
        exp_apb.push_back(mk(read_crc15, 1'b0, 32'h0));
        exp_res.push_back({1'b0, 16'h57A3});
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'h33, 1'b1, 1'b0);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL crc15_valid: res_valid_o=%0b required 1", res_valid_o);
        end
        r = exp_res.pop_front();
        checks++;
        if ({res_err_o, res_crc_o} !== r) begin
            failures++;
            $display("FAIL crc15_result: err/crc=%h required %h", {res_err_o, res_crc_o}, r);
        end
        release_result();
        checks++;
        if (obs_apb.size() != exp_apb.size()) begin
            failures++;
            $display("FAIL crc15_apb_count: got %0d required %0d", obs_apb.size(), exp_apb.size());
        end
        while (exp_apb.size() > 0 && obs_apb.size() > 0) begin
            e = exp_apb.pop_front();
            o = obs_apb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL crc15_apb_xfer: got %h required %h", o, e);
            end
        end
        exp_apb.delete();
        obs_apb.delete();
    endtask

    task automatic test_timeout();
        bit ok;
        logic [16:0] r;
        never_ready = 1'b1;
        m_dat_i = 32'h0000_FFFF;
        sel_cycles = 0;
        en_cycles = 0;
        exp_res.push_back({1'b1, 16'h0000});
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h44, 1'b1, 1'b0);
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_valid: res_valid_o=%0b required 1", res_valid_o);
        end
        r = exp_res.pop_front();
        checks++;
        if ({res_err_o, res_crc_o} !== r) begin
            failures++;
            $display("FAIL timeout_result: err/crc=%h required %h", {res_err_o, res_crc_o}, r);
        end
        checks++;
        if (en_cycles != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_access_cycles: got %0d required %0d", en_cycles, TIMEOUT);
        end
        checks++;
        if (sel_cycles != TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_sel_cycles: got %0d required %0d", sel_cycles, TIMEOUT + 1);
        end
        checks++;
        if (obs_apb.size() != 0) begin
            failures++;
            $display("FAIL timeout_apb_count: got %0d required 0", obs_apb.size());
        end
        release_result();
        obs_apb.delete();
        never_ready = 1'b0;
    endtask

    task automatic test_result_hold();
        bit ok;
        apb_t e, o;
        logic [16:0] r;
        wait_cycles = 0;
        m_dat_i = 32'h0000_1212;
        exp_apb.push_back(mk(write_crc8, 1'b1, 32'h0000_005A));
        exp_apb.push_back(mk(read_crc8, 1'b0, 32'h0));
        exp_res.push_back({1'b0, 16'h0012});
        send_byte(8'h5A, 1'b1, 1'b0);
        wait_valid(ok);
        r = exp_res.pop_front();
        s_dat_i = 8'hEE;
        s_last_i = 1'b1;
        s_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({res_valid_o, res_err_o, res_crc_o, s_ready_o, m_sel_o} !== {1'b1, r, 2'b00}) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid/err/crc/ready/sel=%h required %h", i,
                         {res_valid_o, res_err_o, res_crc_o, s_ready_o, m_sel_o}, {1'b1, r, 2'b00});
            end
            @(negedge p_clk_i);
        end
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
        release_result();
        @(negedge p_clk_i);
        checks++;
        if ({res_valid_o, s_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release: valid/ready=%b required 01", {res_valid_o, s_ready_o});
        end
        checks++;
        if (obs_apb.size() != exp_apb.size()) begin
            failures++;
            $display("FAIL hold_apb_count: got %0d required %0d", obs_apb.size(), exp_apb.size());
        end
        while (exp_apb.size() > 0 && obs_apb.size() > 0) begin
            e = exp_apb.pop_front();
            o = obs_apb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hold_apb_xfer: got %h required %h", o, e);
            end
        end
        exp_apb.delete();
        obs_apb.delete();
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        int n;
        logic [85:0] outs;
        apb_t e, o;
        logic [16:0] r;
        never_ready = 1'b1;
        send_byte(8'h77, 1'b1, 1'b0);
        n = 0;
        @(negedge p_clk_i);
        while (!m_enable_o && n < 20) begin
            @(negedge p_clk_i);
            n++;
        end
        checks++;
        if (m_enable_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_reach_access: m_enable_o=%0b required 1", m_enable_o);
        end
        p_rst_i = 1'b1;
        @(posedge p_clk_i);
        #1;
        p_rst_i = 1'b0;
        res_cycles = 0;
        @(negedge p_clk_i);
        outs = {s_ready_o, m_adr_o, m_dat_o, m_sel_o, m_enable_o, m_we_o,
                res_crc_o, res_err_o, res_valid_o};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %h required 0", outs);
        end
        repeat (5) @(negedge p_clk_i);
        checks++;
        if (res_cycles != 0 || obs_apb.size() != 0) begin
            failures++;
            $display("FAIL rstmid_no_result: res cycles=%0d apb=%0d required 0 0", res_cycles, obs_apb.size());
        end
        never_ready = 1'b0;
        wait_cycles = 0;
        m_dat_i = 32'h0000_F00D;
        exp_apb.push_back(mk(write_crc15, 1'b1, 32'h0000_0001));
        exp_apb.push_back(mk(read_crc15, 1'b0, 32'h0));
        exp_res.push_back({1'b0, 16'h700D});
        send_byte(8'h01, 1'b1, 1'b1);
        wait_valid(ok);
        r = exp_res.pop_front();
        checks++;
        if ({res_err_o, res_crc_o} !== r) begin
            failures++;
            $display("FAIL rstmid_result: err/crc=%h required %h", {res_err_o, res_crc_o}, r);
        end
        release_result();
        checks++;
        if (obs_apb.size() != exp_apb.size()) begin
            failures++;
            $display("FAIL rstmid_apb_count: got %0d required %0d", obs_apb.size(), exp_apb.size());
        end
        while (exp_apb.size() > 0 && obs_apb.size() > 0) begin
            e = exp_apb.pop_front();
            o = obs_apb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rstmid_apb_xfer: got %h required %h", o, e);
            end
        end
        exp_apb.delete();
        obs_apb.delete();
    endtask

    task automatic test_latency();
        bit ok;
        int lat;
        logic [16:0] r;
        wait_cycles = 0;
        never_ready = 1'b0;
        m_dat_i = 32'h0000_00E1;
        exp_res.push_back({1'b0, 16'h00E1});
        send_byte(8'hC3, 1'b1, 1'b0);
        wait_valid(ok);
        lat = cyc - acc_cyc + 1;
        checks++;
        if (!ok || lat != 5) begin
            failures++;
            $display("FAIL latency: edges from accept=%0d valid=%0b required 5 1", lat, ok);
        end
        r = exp_res.pop_front();
        checks++;
        if ({res_err_o, res_crc_o} !== r) begin
            failures++;
            $display("FAIL latency_result: err/crc=%h required %h", {res_err_o, res_crc_o}, r);
        end
        release_result();
        obs_apb.delete();
    endtask

    initial begin
        test_reset();
        test_crc8_frame();
        test_crc15_frame();
        test_timeout();
        test_result_hold();
        test_reset_mid_transfer();
        test_latency();
        repeat (2) @(negedge p_clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_apb_master.md
Name: crc_apb_master

Overview:
- Upstream feeder for the APB CRC8/CRC15 wrapper.
- Accepts a framed byte stream (valid/ready, last flag) and issues one APB write per byte to the selected CRC write register.
- After the last byte, issues one APB read of the matching result register and presents the CRC on a result handshake port.
- Sits between a byte source (UART RX/DMA) and the wrapper's APB slave port.

Parameters:
- TIMEOUT, 16: max ACCESS cycles waiting for m_ready_i before abort (>=2).
- ADDR_W, 32: APB address width.
- DATA_W, 32: APB data width.

Ports:
- p_clk_i  in  1  single clock, all logic on rising edge.
- p_rst_i  in  1  reset, synchronous, active-high.
- s_dat_i  in  8  stream byte.
- s_valid_i  in  1  byte valid.
- s_last_i  in  1  byte is last of frame.
- s_sel15_i  in  1  0=CRC8, 1=CRC15; sampled only with first byte of frame.
- s_ready_o  out  1  byte accepted when s_valid_i&&s_ready_o.
- m_adr_o  out  ADDR_W  APB address.
- m_dat_o  out  DATA_W  APB write data.
- m_dat_i  in  DATA_W  APB read data.
- m_sel_o  out  1  APB select.
- m_enable_o  out  1  APB enable.
- m_we_o  out  1  APB write strobe.
- m_ready_i  in  1  APB ready from slave.
- res_crc_o  out  16  CRC result, zero-extended.
- res_err_o  out  1  frame aborted by timeout; qualified by res_valid_o.
- res_valid_o  out  1  result valid, held until res_ready_i.
- res_ready_i  in  1  result consumer ready.

Behaviour:
- Reset values (next edge after p_rst_i=1): all outputs 0; FSM=IDLE; frame_active=0; discard=0; timeout counter=0.
- Reset mid-transfer aborts immediately. The in-flight byte is dropped and no result is emitted.
- FSM states: IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RESULT.
- IDLE:
  - s_ready_o=1.
  - On accept: latch byte and last flag.
  - If !frame_active: latch s_sel15_i and set frame_active.
  - Goto WR_SETUP, or stay in IDLE if discard=1.
  - With discard=1, an accepted last byte clears discard and frame_active and goes to RESULT with err=1.
- WR_SETUP (one cycle): m_sel_o=1, m_enable_o=0, m_we_o=1, m_adr_o=write_crc8/write_crc15, m_dat_o={24'b0,byte}.
- WR_ACCESS: same signals plus m_enable_o=1. Hold until m_ready_i is sampled high.
  - Then, if last: goto RD_SETUP; else goto IDLE.
  - APB signals return to 0 in the next state.
- RD_SETUP/RD_ACCESS: as above with m_we_o=0, m_adr_o=read_crc8/read_crc15, m_dat_o=0.
  - On m_ready_i: capture res_crc_o = sel15 ? {1'b0,m_dat_i[14:0]} : {8'b0,m_dat_i[7:0]}.
  - Set err=0, clear frame_active, goto RESULT.
- RESULT: res_valid_o=1, s_ready_o=0. Outputs held stable until res_ready_i=1, then IDLE with res_valid_o=0 next cycle.
- Timeout:
  - Counter increments each ACCESS cycle with m_ready_i=0 and clears on leaving ACCESS.
  - When the TIMEOUT-th ACCESS cycle also sees m_ready_i=0: deassert APB next cycle.
  - Write of non-last byte: set discard, goto IDLE. Remaining bytes of the frame are accepted and dropped.
  - Write of last byte, or a read: goto RESULT with err=1, res_crc_o=0, and clear frame_active.
- m_ready_i asserted in the same cycle as the timeout limit counts as success.
- Latency, single-byte frame with zero-wait slave:
  - accept at edge N; WR_SETUP N+1; WR_ACCESS N+2; RD_SETUP N+3; RD_ACCESS N+4; res_valid_o high from N+5.
- Back-to-back bytes: at most one byte per 3 cycles. There is no pipelining and exactly one APB transaction is outstanding.
- m_ready_i and m_dat_i are ignored outside ACCESS states.

Decomposition:
- crc_pkg, shared with the wrapper, holds:
  - address constants write_crc8, read_crc8, write_crc15, read_crc15;
  - the FSM state enum typedef crc_mst_state_t;
  - localparam CRC8_W=8, CRC15_W=15.
- One sub-module: apb_wait_timer, a counter with clear/enable and a TIMEOUT parameter that outputs expired.
- The address mux and result extraction stay inline.

Test Plan:
- Frame {0xAA, 0x33 last}, sel15=0, slave model ready after 1 wait, returns 0x000000C5 on read -> two writes to write_crc8 with m_dat_o 0xAA then 0x33, one read from read_crc8, res_crc_o=0x00C5, res_err_o=0.
- Same frame, sel15=1, read returns 0x0000D7A3 -> addresses write_crc15/read_crc15, res_crc_o=0x57A3 (bit15 masked), sel15 toggling on the second byte is ignored.
- Slave never asserts m_ready_i on the first write of a 3-byte frame, TIMEOUT=16 -> m_sel_o drops after 16 ACCESS cycles, next two bytes accepted with no APB activity, one result with res_err_o=1, res_crc_o=0.
- res_ready_i held low for 10 cycles during RESULT -> res_valid_o/res_crc_o stable, s_ready_o=0, no APB activity; release -> IDLE next cycle.
- p_rst_i pulsed for 1 cycle during WR_ACCESS -> all outputs 0 at the next edge, no result emitted; new frame {0x01 last} then completes normally.
- Zero-wait slave, single-byte frame -> res_valid_o asserted exactly 5 cycles after the accept edge.
